// File: rtl/data_mem_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory: one req/ack
// transaction per access, pipeline stall while busy, timeout abort.
module data_mem_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [1:0]        mem_ctrl_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              err_o,
   output logic [15:0]       stall_cnt_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] tmo_cnt;
   logic       tmo_hit;
   logic       cs;

   assign cs      = mem_ctrl_i[1];
   assign tmo_hit = (tmo_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   // DONE never launches a new access: EX/MEM still holds the serviced instruction
   always_comb begin
      next_state = state;
      stall_o    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs) begin
               stall_o    = 1'b1;
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            stall_o = 1'b1;
            if (mem_ack_i || tmo_hit) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_req_o     <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_addr_o    <= '0;
         mem_wdata_o   <= '0;
         rdata_o       <= '0;
         rdata_valid_o <= 1'b0;
         err_o         <= 1'b0;
         stall_cnt_o   <= 16'h0000;
         tmo_cnt       <= 8'h00;
      end else begin
         rdata_valid_o <= 1'b0;
         err_o         <= 1'b0;
         if (stall_o && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
         unique case (state)
            IDLE: begin
               if (cs) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= mem_ctrl_i[0];
                  mem_addr_o  <= addr_i;
                  mem_wdata_o <= wdata_i;
                  tmo_cnt     <= 8'h00;
               end
            end
            // ack takes priority over an expiring timeout in the same cycle
            ACCESS: begin
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  if (!mem_we_o) begin
                     rdata_o       <= mem_rdata_i;
                     rdata_valid_o <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  mem_req_o <= 1'b0;
                  err_o     <= 1'b1;
                  rdata_o   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE:    ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a TIMEOUT=8 instance for the transaction
// tests and a TIMEOUT=255 instance held busy to drive the stall counter to saturation.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mem_ctrl;
   logic [31:0] addr, wdata, mem_rdata;
   logic        ack;
   logic        stall, rdata_valid, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [15:0] stall_cnt;

   logic        sat_rst;
   logic [1:0]  sat_ctrl = 2'b10;
   logic [31:0] sat_zero = 32'h0;
   logic        sat_ack  = 1'b0;
   logic        sat_stall, sat_valid, sat_err, sat_req, sat_we;
   logic [31:0] sat_rdata, sat_addr, sat_wdata;
   logic [15:0] sat_cnt;
   int          sat_cycle;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DATA_W(32), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst), .mem_ctrl_i(mem_ctrl), .addr_i(addr), .wdata_i(wdata),
      .stall_o(stall), .rdata_o(rdata), .rdata_valid_o(rdata_valid), .err_o(err),
      .stall_cnt_o(stall_cnt), .mem_req_o(mem_req), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ack_i(ack), .mem_rdata_i(mem_rdata)
   );

   data_mem_ctrl #(.DATA_W(32), .TIMEOUT(255)) sat_dut (
      .clk_i(clk), .rst_i(sat_rst), .mem_ctrl_i(sat_ctrl), .addr_i(sat_zero), .wdata_i(sat_zero),
      .stall_o(sat_stall), .rdata_o(sat_rdata), .rdata_valid_o(sat_valid), .err_o(sat_err),
      .stall_cnt_o(sat_cnt), .mem_req_o(sat_req), .mem_we_o(sat_we),
      .mem_addr_o(sat_addr), .mem_wdata_o(sat_wdata), .mem_ack_i(sat_ack), .mem_rdata_i(sat_zero)
   );

   // cycle index of the saturation instance since its reset release
   always @(posedge clk) begin
      if (sat_rst) sat_cycle <= 0;
      else         sat_cycle <= sat_cycle + 1;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [1:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] wd, input logic ak, input logic [31:0] rd);
      mem_ctrl  = ctrl;
      addr      = a;
      wdata     = wd;
      ack       = ak;
      mem_rdata = rd;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; sat_rst = 1'b1;
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      next_cycle();
      check_output("reset_req", mem_req, 0);
      check_output("reset_we", mem_we, 0);
      check_output("reset_addr", mem_addr, 0);
      check_output("reset_wdata", mem_wdata, 0);
      check_output("reset_rdata", rdata, 0);
      check_output("reset_valid", rdata_valid, 0);
      check_output("reset_err", err, 0);
      check_output("reset_cnt", stall_cnt, 0);
      rst = 1'b0; sat_rst = 1'b0;

      // load, zero-wait ack
      apply_stimulus(2'b10, 32'h10, 32'h0, 1'b0, 32'h0);
      check_output("ld0_stall", stall, 1);
      check_output("ld0_req", mem_req, 0);
      next_cycle();
      apply_stimulus(2'b10, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
      check_output("ld1_req", mem_req, 1);
      check_output("ld1_stall", stall, 1);
      check_output("ld1_addr", mem_addr, 32'h10);
      check_output("ld1_we", mem_we, 0);
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("ld2_valid", rdata_valid, 1);
      check_output("ld2_rdata", rdata, 32'hDEADBEEF);
      check_output("ld2_cnt", stall_cnt, 2);
      check_output("ld2_stall", stall, 0);
      check_output("ld2_req", mem_req, 0);
      check_output("ld2_err", err, 0);
      next_cycle();
      check_output("ld3_valid", rdata_valid, 0);

      // store, ack after 4 cycles
      apply_stimulus(2'b11, 32'h20, 32'h12345678, 1'b0, 32'h0);
      check_output("st0_stall", stall, 1);
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         apply_stimulus(2'b11, 32'h20, 32'h12345678, (c == 4), 32'hFFFFFFFF);
         check_output("st_req", mem_req, 1);
         check_output("st_we", mem_we, 1);
         check_output("st_addr", mem_addr, 32'h20);
         check_output("st_wdata", mem_wdata, 32'h12345678);
         check_output("st_stall", stall, 1);
      end
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("st5_valid", rdata_valid, 0);
      check_output("st5_rdata", rdata, 32'hDEADBEEF);
      check_output("st5_cnt", stall_cnt, 7);
      check_output("st5_stall", stall, 0);
      next_cycle();

      // timeout, ack never arrives
      apply_stimulus(2'b10, 32'h30, 32'h0, 1'b0, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         check_output("to_req", mem_req, 1);
         check_output("to_err_low", err, 0);
      end
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("to9_err", err, 1);
      check_output("to9_rdata", rdata, 0);
      check_output("to9_valid", rdata_valid, 0);
      check_output("to9_req", mem_req, 0);
      check_output("to9_cnt", stall_cnt, 16);
      next_cycle();

      // ack on the last timeout cycle (IDLE start proves the return from DONE)
      apply_stimulus(2'b10, 32'h40, 32'h0, 1'b0, 32'h0);
      check_output("ta0_err", err, 0);
      check_output("ta0_stall", stall, 1);
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         apply_stimulus(2'b10, 32'h40, 32'h0, (c == 8), 32'hCAFEF00D);
         check_output("ta_req", mem_req, 1);
      end
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("ta9_valid", rdata_valid, 1);
      check_output("ta9_err", err, 0);
      check_output("ta9_rdata", rdata, 32'hCAFEF00D);
      check_output("ta9_cnt", stall_cnt, 25);
      next_cycle();

      // reset in the middle of a load
      apply_stimulus(2'b10, 32'h50, 32'h0, 1'b0, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      check_output("rs2_req", mem_req, 1);
      next_cycle();
      rst = 1'b0;
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("rs3_req", mem_req, 0);
      check_output("rs3_cnt", stall_cnt, 0);
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b1, 32'h11111111);
      check_output("rs4_req", mem_req, 0);
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("rs5_valid", rdata_valid, 0);
      check_output("rs5_err", err, 0);
      check_output("rs5_rdata", rdata, 0);
      check_output("rs5_req", mem_req, 0);
      check_output("rs5_cnt", stall_cnt, 0);

      // clean transaction after reset
      apply_stimulus(2'b10, 32'h60, 32'h0, 1'b0, 32'h0);
      next_cycle();
      apply_stimulus(2'b10, 32'h60, 32'h0, 1'b1, 32'h55AA55AA);
      check_output("cl1_addr", mem_addr, 32'h60);
      check_output("cl1_req", mem_req, 1);
      next_cycle();
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      check_output("cl2_valid", rdata_valid, 1);
      check_output("cl2_rdata", rdata, 32'h55AA55AA);
      check_output("cl2_cnt", stall_cnt, 2);
      next_cycle();

      // back-to-back with cs and ack held high: one transaction every 3 cycles
      apply_stimulus(2'b10, 32'h70, 32'h0, 1'b1, 32'h0BADF00D);
      for (int r = 0; r < 3; r++) begin
         check_output("bb_idle_stall", stall, 1);
         check_output("bb_idle_req", mem_req, 0);
         next_cycle();
         check_output("bb_acc_stall", stall, 1);
         check_output("bb_acc_req", mem_req, 1);
         next_cycle();
         check_output("bb_done_stall", stall, 0);
         check_output("bb_done_valid", rdata_valid, 1);
         check_output("bb_done_rdata", rdata, 32'h0BADF00D);
         next_cycle();
      end
      check_output("bb_cnt", stall_cnt, 8);
      apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);

      // saturation instance: cycle N holds N - floor(N/257) before the clamp
      while (sat_cycle < 600) next_cycle();
      check_output("sat_600", sat_cnt, 598);
      while (sat_cycle < 66000) next_cycle();
      check_output("sat_ffff", sat_cnt, 16'hFFFF);
      while (sat_cycle < 66300) next_cycle();
      check_output("sat_hold", sat_cnt, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Sequencer between the MEM pipeline stage and a variable-latency data memory. It takes the MEM control pair {MEM_cs, MEM_we} from the EX/MEM register and runs one request/acknowledge transaction per access. It freezes the pipeline with `stall_o` until the memory responds or a timeout expires, then hands load data to the MEM/WB register.

## Interface
Parameters:
- `DATA_W`, 32, data and address width
- `TIMEOUT`, 255, maximum cycles spent in ACCESS before abort (1..255)

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `mem_ctrl_i`  in  2  {MEM_cs, MEM_we} from EX/MEM; cs=1 requests an access, we=1 makes it a store
- `addr_i`  in  DATA_W  byte address (ALU result)
- `wdata_i`  in  DATA_W  store data
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `rdata_o`  out  DATA_W  captured load data
- `rdata_valid_o`  out  1  one-cycle pulse; `rdata_o` valid for a completed load
- `err_o`  out  1  one-cycle pulse; access aborted by timeout
- `stall_cnt_o`  out  16  saturating count of stalled cycles
- `mem_req_o`  out  1  request to data memory
- `mem_we_o`  out  1  store qualifier, valid while `mem_req_o`
- `mem_addr_o`  out  DATA_W  registered address
- `mem_wdata_o`  out  DATA_W  registered store data
- `mem_ack_i`  in  1  memory completion; sampled only in ACCESS
- `mem_rdata_i`  in  DATA_W  load data, valid with `mem_ack_i`

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If `mem_ctrl_i[1]`=1, latch addr/wdata/we into the `mem_*` registers, clear the timeout counter, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - `mem_req_o`=1. Address, data and we are held stable.
  - If `mem_ack_i`=1, go to DONE. For a load, capture `mem_rdata_i` into `rdata_o` and set `rdata_valid_o` for the DONE cycle.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack, go to DONE with `err_o` for the DONE cycle and `rdata_o`=0. No `rdata_valid_o` is raised on timeout.
  - Ack wins over timeout when both occur in the same cycle.
- DONE:
  - `stall_o`=0, and the pipeline advances this cycle.
  - Always return to IDLE. Do not start a new access from DONE: the EX/MEM contents still hold the serviced instruction.
- `stall_o` = (IDLE and `mem_ctrl_i[1]`) or ACCESS. This is combinational from state and `mem_ctrl_i`, and is the only combinational output.
- `stall_cnt_o` increments on every cycle with `stall_o`=1 and saturates at 0xFFFF.
- Stores and loads use an identical handshake. `rdata_o` is unchanged after a store.
- `mem_ctrl_i[0]` is ignored when `mem_ctrl_i[1]`=0. `mem_ack_i` is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_o`=0, `rdata_valid_o`=0, `err_o`=0, `stall_cnt_o`=0, timeout counter 0.
- Stall and completion, with cs seen in IDLE at cycle 0 and the first ack at cycle k (k≥1):
  - `mem_req_o` is high cycles 1..k.
  - DONE is at cycle k+1 with the pulses and `stall_o`=0.
  - Stall cycles = k+1, so a zero-wait memory (ack at cycle 1) costs 2 stall cycles.
- Timeout path: req is high for exactly TIMEOUT cycles, then DONE with `err_o`.
- Back-to-back accesses: IDLE must be entered for at least one cycle between transactions. The minimum spacing between requests is 3 cycles.
- Reset mid-ACCESS: `mem_req_o` drops on the next edge and no pulses are produced. An ack arriving afterwards is ignored.
- Reset also clears `stall_cnt_o`.

## Test plan
- Load with zero-wait ack: cs=1, we=0, addr=0x10 at cycle 0; ack at cycle 1 with rdata=0xDEADBEEF. Required: req high cycle 1 only; `stall_o` high cycles 0–1; cycle 2 has `rdata_valid_o`=1, `rdata_o`=0xDEADBEEF, `stall_cnt_o`=2.
- Store with 4-cycle latency: we=1, addr=0x20, wdata=0x12345678; ack at cycle 4. Required: `mem_we_o`=1 and stable addr/data on cycles 1–4; stall for 5 cycles; no `rdata_valid_o`; `rdata_o` unchanged.
- Timeout with TIMEOUT=8 and ack never asserted. Required: req for 8 cycles; `err_o` pulse at cycle 9; `rdata_o`=0; return to IDLE.
- Ack on the final timeout cycle with TIMEOUT=8. Required: ack honoured, `rdata_valid_o`=1, `err_o`=0.
- Reset mid-operation: assert `rst_i` at cycle 2 of a load, then ack at cycle 4. Required: req low from cycle 3; no pulses; `stall_cnt_o`=0; next cs starts a clean transaction.
- Saturation and back-to-back: hold cs=1 continuously. Required: one transaction per 3 cycles with `stall_o` low only in DONE; preload the count near 0xFFFF via a long stall, and it holds at 0xFFFF.
